snpu_session_master: RTL and testbench
======================================

// Module: snpu_session_master
// PURPOSE
//  Command initiator for the SNPU deck core's 8-bit op bus. One start request runs a full legislative session:
//  - optional reshuffle, president peek of 3 cards, president discard, chancellor peek of 2 cards,
//  - chancellor discard, play, board readback.
//  Sits between player-facing UI logic and the deck core. Presents session results and win flags.
// PARAMETERS
//  DECK_SIZE   17  total policy cards in the deck
//  WIN_ZEROS   5   zeros-on-board count that raises win_zero
//  WIN_ONES    6   ones-on-board count that raises win_one
//  RSP_TIMEOUT 255 max cycles waiting for rsp_valid; only used with SNPU_SESSION_TIMEOUT_EN
// PORTS
//  clk        in  1  clock
//  rst_n      in  1  asynchronous active-low reset
//  start      in  1  begin session; sampled only in IDLE
//  p_idx      in  2  president discard index, legal range 0..2
//  c_idx      in  1  chancellor discard index, 0..1
//  busy       out 1  high from accepted start until done/err
//  cmd        out 8  {op[2:0], arg[4:0]} to core
//  cmd_valid  out 1  cmd is valid
//  cmd_ready  in  1  core accepts cmd
//  rsp        in  8  core response byte
//  rsp_valid  in  1  response strobe, 1 cycle
//  peek3      out 3  president hand; bit i = card at hand index i
//  peek2      out 2  chancellor hand
//  played     out 1  policy enacted this session
//  board_zero out 4  zeros on board
//  board_one  out 4  ones on board
//  win_zero   out 1  board_zero >= WIN_ZEROS (level)
//  win_one    out 1  board_one >= WIN_ONES (level)
//  done       out 1  1-cycle pulse, session complete
//  err        out 1  1-cycle pulse, session rejected or aborted
// BEHAVIOUR
//  Reset: all outputs 0; stk_cnt = DECK_SIZE; FSM = IDLE.
//  Op encoding: 000 RESET, 011 SHUFFLE, 100 HAND_DISPLAY, 101 HAND_DISCARD, 110 HAND_PLAY, 111 BOARD_DISPLAY.
//  Command transfer: cmd_valid rises, cmd held stable until the cycle with cmd_valid & cmd_ready.
//  - cmd_valid drops the next cycle.
//  - FSM then waits for rsp_valid; exactly one response per command.
//  - Non-data ops return 8'h00; the master does not check the value.
//  Response formats:
//  - HAND_DISPLAY returns the card in rsp[0].
//  - BOARD_DISPLAY returns {ones[7:4], zeros[3:0]}.
//  FSM: IDLE -> [SHUF if stk_cnt<3] -> PK0 -> PK1 -> PK2 -> DISP(p_idx) -> CK0 -> CK1 -> DISC(c_idx) -> PLAY(arg 0) -> BOARD -> DONE -> IDLE.
//  Each non-IDLE/DONE state issues one command and advances on its response.
//  start with p_idx==3: err pulse, no command issued, stays IDLE.
//  start while win_zero|win_one already set: err pulse, stays IDLE.
//  Deck accounting:
//  - stk_cnt -= 3 on PLAY response.
//  - On SHUFFLE response, stk_cnt = DECK_SIZE - (board_zero+board_one), using the last board values.
//  - Unsigned 5-bit arithmetic; underflow cannot occur by construction.
//  played = rsp[0] of the CK-stage card not discarded, latched on PLAY response.
//  Board and win outputs update on the BOARD response; done pulses the following cycle.
//  start while busy: ignored.
//  Async reset mid-session: abandons the session immediately.
// CONFIGURATION
//  SNPU_SESSION_TIMEOUT_EN defined:
//  - Counter runs while waiting for rsp_valid.
//  - Reaching RSP_TIMEOUT: err pulse, cmd_valid low, FSM -> IDLE, stk_cnt unchanged from last completed step.
//  Undefined: waits indefinitely; RSP_TIMEOUT unused.
// STRUCTURE
//  Package snpu_pkg: op codes (OP_RESET..OP_BOARD_DISPLAY), DECK_SIZE default, FSM state enum, cmd field slices.
//  Sub-module snpu_cmd_port: owns cmd/cmd_valid hold and response wait (plus timeout counter).
//  - Handshake to FSM: issue/op/arg in, rsp_done/rsp_data/timeout out.
// TESTING
//  - Reset, start p_idx=1 c_idx=0, core peeks 1,0,1 then 0,1 -> cmd seq 0x80,0x81,0x82,0xA1,0x80,0x81,0xA0,0xC0,0xE0; played=1; done once.
//  - Core holds cmd_ready low 5 cycles -> cmd and cmd_valid stable all 5 cycles, single transfer.
//  - Five sessions from reset (stk 17,14,11,8,5,2) -> sixth session issues 0x60 SHUFFLE first.
//  - Sixth session with board 2/3 -> stk_cnt=12 before PK0.
//  - start with p_idx=3 -> err pulse next cycle, cmd_valid never rises.
//  - BOARD response 8'h60 -> board_one=6, win_one=1; next start -> err.
//  - With SNPU_SESSION_TIMEOUT_EN, no rsp_valid after PK1 -> err after 255 cycles, busy=0.
//  - Assert rst_n low during DISP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/snpu_pkg.sv
// Shared definitions for the SNPU session master.
// Holds the deck-core op codes, the default deck size, the session FSM
// state encoding and the command byte packing helper.
// The optional response timeout is SNPU_SESSION_TIMEOUT_EN; it lives in
// snpu_cmd_port.
package snpu_pkg;

    localparam int DECK_SIZE_DEF = 17;
    localparam int ARG_W         = 5;

    // Command byte is {op[2:0], arg[4:0]}
    localparam logic [2:0] OP_RESET         = 3'b000;
    localparam logic [2:0] OP_SHUFFLE       = 3'b011;
    localparam logic [2:0] OP_HAND_DISPLAY  = 3'b100;
    localparam logic [2:0] OP_HAND_DISCARD  = 3'b101;
    localparam logic [2:0] OP_HAND_PLAY     = 3'b110;
    localparam logic [2:0] OP_BOARD_DISPLAY = 3'b111;

    // Session FSM states
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SHUF  = 4'd1;
    localparam logic [3:0] ST_PK0   = 4'd2;
    localparam logic [3:0] ST_PK1   = 4'd3;
    localparam logic [3:0] ST_PK2   = 4'd4;
    localparam logic [3:0] ST_DISP  = 4'd5;
    localparam logic [3:0] ST_CK0   = 4'd6;
    localparam logic [3:0] ST_CK1   = 4'd7;
    localparam logic [3:0] ST_DISC  = 4'd8;
    localparam logic [3:0] ST_PLAY  = 4'd9;
    localparam logic [3:0] ST_BOARD = 4'd10;
    localparam logic [3:0] ST_DONE  = 4'd11;

    function automatic logic [7:0] make_cmd(input logic [2:0] op,
                                            input logic [ARG_W-1:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/snpu_cmd_port.sv
// Command port of the SNPU session master.
// Latches one command on issue, holds cmd/cmd_valid until the core accepts
// it, then waits for the single response strobe.
// Ports: clk, rst_n (async active-low); issue/op/arg from the FSM;
// cmd/cmd_valid/cmd_ready to the core; rsp/rsp_valid from the core;
// rsp_done/rsp_data/timeout back to the FSM.
// Macro SNPU_SESSION_TIMEOUT_EN: abort the wait after RSP_TIMEOUT cycles.
module snpu_cmd_port
    import snpu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [2:0]       op,
    input  logic [ARG_W-1:0] arg,
    output logic [7:0]       cmd,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic [7:0]       rsp,
    input  logic             rsp_valid,
    output logic             rsp_done,
    output logic [7:0]       rsp_data,
    output logic             timeout
);

    logic waiting;

    // A strobe outside the response window belongs to no command and is ignored
    assign rsp_done = waiting & rsp_valid;
    assign rsp_data = rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
            waiting   <= 1'b0;
        end else if (issue) begin
            cmd       <= make_cmd(op, arg);
            cmd_valid <= 1'b1;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            waiting   <= 1'b1;
        end else if (rsp_done || timeout) begin
            waiting   <= 1'b0;
        end
    end

`ifdef SNPU_SESSION_TIMEOUT_EN
    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!waiting || rsp_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the RSP_TIMEOUT-th cycle spent waiting without a response
    assign timeout = waiting && !rsp_valid && (tmo_cnt == TW'(RSP_TIMEOUT - 1));
`else
    // Never fires: the port waits for the response indefinitely
    assign timeout = 1'b0 && (RSP_TIMEOUT > 0);
`endif

endmodule

// File: rtl/snpu_session_master.sv
// SNPU session master: runs one legislative session per accepted start.
// Sequence: [shuffle if fewer than 3 cards] -> peek 3 -> president discard
// -> peek 2 -> chancellor discard -> play -> board readback.
// Ports: clk, rst_n (async active-low); start, p_idx, c_idx from the UI;
// cmd/cmd_valid/cmd_ready/rsp/rsp_valid to the deck core; busy, peek3,
// peek2, played, board_zero, board_one, win_zero, win_one, done, err.
// Macro SNPU_SESSION_TIMEOUT_EN (in snpu_cmd_port) enables the response
// timeout, which aborts the session with an err pulse.
module snpu_session_master
    import snpu_pkg::*;
#(
    parameter int DECK_SIZE   = DECK_SIZE_DEF,
    parameter int WIN_ZEROS   = 5,
    parameter int WIN_ONES    = 6,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] p_idx,
    input  logic       c_idx,
    output logic       busy,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic [7:0] rsp,
    input  logic       rsp_valid,
    output logic [2:0] peek3,
    output logic [1:0] peek2,
    output logic       played,
    output logic [3:0] board_zero,
    output logic [3:0] board_one,
    output logic       win_zero,
    output logic       win_one,
    output logic       done,
    output logic       err
);

    logic [3:0]       state;
    logic             issued;
    logic [4:0]       stk_cnt;
    logic [1:0]       p_sel;
    logic             c_sel;
    logic             issue;
    logic [2:0]       op;
    logic [ARG_W-1:0] arg;
    logic             rsp_done;
    logic [7:0]       rsp_data;
    logic             timeout;

    always_comb begin
        op  = OP_RESET;
        arg = '0;
        case (state)
            ST_SHUF:  op = OP_SHUFFLE;
            ST_PK0:   op = OP_HAND_DISPLAY;
            ST_PK1:   begin op = OP_HAND_DISPLAY; arg = 5'd1; end
            ST_PK2:   begin op = OP_HAND_DISPLAY; arg = 5'd2; end
            ST_DISP:  begin op = OP_HAND_DISCARD; arg = {3'b000, p_sel}; end
            ST_CK0:   op = OP_HAND_DISPLAY;
            ST_CK1:   begin op = OP_HAND_DISPLAY; arg = 5'd1; end
            ST_DISC:  begin op = OP_HAND_DISCARD; arg = {4'b0000, c_sel}; end
            ST_PLAY:  op = OP_HAND_PLAY;
            ST_BOARD: op = OP_BOARD_DISPLAY;
            default:  ;
        endcase
    end

    // Each command state issues exactly once; issued clears when it advances
    assign issue = (state != ST_IDLE) && (state != ST_DONE) && !issued;

    snpu_cmd_port #(
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) u_cmd_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .op        (op),
        .arg       (arg),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp       (rsp),
        .rsp_valid (rsp_valid),
        .rsp_done  (rsp_done),
        .rsp_data  (rsp_data),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            issued     <= 1'b0;
            stk_cnt    <= 5'(DECK_SIZE);
            p_sel      <= '0;
            c_sel      <= 1'b0;
            busy       <= 1'b0;
            peek3      <= '0;
            peek2      <= '0;
            played     <= 1'b0;
            board_zero <= '0;
            board_one  <= '0;
            win_zero   <= 1'b0;
            win_one    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (issue) issued <= 1'b1;

            if (state == ST_IDLE) begin
                if (start) begin
                    // Index 3 is not a hand position; a won game takes no more sessions
                    if (p_idx == 2'd3 || win_zero || win_one) begin
                        err <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                        p_sel <= p_idx;
                        c_sel <= c_idx;
                        state <= (stk_cnt < 5'd3) ? ST_SHUF : ST_PK0;
                    end
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (timeout) begin
                err    <= 1'b1;
                busy   <= 1'b0;
                issued <= 1'b0;
                state  <= ST_IDLE;
            end else if (rsp_done) begin
                issued <= 1'b0;
                case (state)
                    ST_SHUF: begin
                        // Everything not on the board returns to the draw pile
                        stk_cnt <= 5'(DECK_SIZE) - (5'(board_zero) + 5'(board_one));
                        state   <= ST_PK0;
                    end
                    ST_PK0:  begin peek3[0] <= rsp_data[0]; state <= ST_PK1; end
                    ST_PK1:  begin peek3[1] <= rsp_data[0]; state <= ST_PK2; end
                    ST_PK2:  begin peek3[2] <= rsp_data[0]; state <= ST_DISP; end
                    ST_DISP: state <= ST_CK0;
                    ST_CK0:  begin peek2[0] <= rsp_data[0]; state <= ST_CK1; end
                    ST_CK1:  begin peek2[1] <= rsp_data[0]; state <= ST_DISC; end
                    ST_DISC: state <= ST_PLAY;
                    ST_PLAY: begin
                        stk_cnt <= stk_cnt - 5'd3;
                        // The enacted policy is the chancellor card that was kept
                        played  <= c_sel ? peek2[0] : peek2[1];
                        state   <= ST_BOARD;
                    end
                    ST_BOARD: begin
                        board_zero <= rsp_data[3:0];
                        board_one  <= rsp_data[7:4];
                        win_zero   <= rsp_data[3:0] >= 4'(WIN_ZEROS);
                        win_one    <= rsp_data[7:4] >= 4'(WIN_ONES);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snpu_session_master.sv
// Testbench for snpu_session_master: a behavioural deck core answers each
// command from a response queue while a scoreboard of expected command
// bytes is checked at every transfer.
module tb_snpu_session_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] p_idx;
    logic       c_idx;
    logic       busy;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp;
    logic       rsp_valid;
    logic [2:0] peek3;
    logic [1:0] peek2;
    logic       played;
    logic [3:0] board_zero;
    logic [3:0] board_one;
    logic       win_zero;
    logic       win_one;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_cmd_q[$];
    logic [7:0] rsp_q[$];
    logic [4:0] stk_at_xfer[$];
    int ready_delay  = 0;
    int rsp_delay    = 0;
    int mute_idx     = -1;
    int xfer_cnt     = 0;
    bit check_stable = 1'b0;

    logic [27:0] all_outs;
    assign all_outs = {busy, cmd, cmd_valid, peek3, peek2, played,
                       board_zero, board_one, win_zero, win_one, done, err};

    always #5 clk = ~clk;

    snpu_session_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .p_idx      (p_idx),
        .c_idx      (c_idx),
        .busy       (busy),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .rsp        (rsp),
        .rsp_valid  (rsp_valid),
        .peek3      (peek3),
        .peek2      (peek2),
        .played     (played),
        .board_zero (board_zero),
        .board_one  (board_one),
        .win_zero   (win_zero),
        .win_one    (win_one),
        .done       (done),
        .err        (err)
    );

    // Behavioural deck core, driven and sampled on the falling edge
    initial begin : core
        logic [7:0] held;
        logic [7:0] exp;
        int         this_idx;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp       = 8'h00;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (rst_n && cmd_valid) begin
                held = cmd;
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    if (check_stable) begin
                        n_tests++;
                        if (cmd !== held || cmd_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL cmd_stall: cmd=%h valid=%b, required cmd=%h valid=1",
                                     cmd, cmd_valid, held);
                        end
                    end
                end
                if (!rst_n) continue;
                cmd_ready = 1'b1;
                n_tests++;
                if (exp_cmd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_extra: cmd=%h, required no command", cmd);
                end else begin
                    exp = exp_cmd_q.pop_front();
                    if (cmd !== exp) begin
                        n_fail++;
                        $display("FAIL cmd_seq: cmd=%h, required %h", cmd, exp);
                    end
                end
                stk_at_xfer.push_back(dut.stk_cnt);
                this_idx = xfer_cnt;
                xfer_cnt++;
                @(negedge clk);
                cmd_ready = 1'b0;
                n_tests++;
                if (cmd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cmd_valid_drop: cmd_valid=%b, required 0", cmd_valid);
                end
                if (this_idx != mute_idx && rst_n) begin
                    for (int i = 0; i < rsp_delay; i++) @(negedge clk);
                    rsp       = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
                    rsp_valid = 1'b1;
                end
            end
        end
    end

    task automatic clear_core;
        exp_cmd_q.delete();
        rsp_q.delete();
        stk_at_xfer.delete();
        mute_idx = -1;
    endtask

    task automatic push_session(input logic [1:0] p, input logic c, input logic [2:0] pk,
                                input logic [1:0] ck, input logic [7:0] board, input bit shuf);
        if (shuf) begin exp_cmd_q.push_back(8'h60); rsp_q.push_back(8'h00); end
        exp_cmd_q.push_back(8'h80); rsp_q.push_back({7'b0, pk[0]});
        exp_cmd_q.push_back(8'h81); rsp_q.push_back({7'b0, pk[1]});
        exp_cmd_q.push_back(8'h82); rsp_q.push_back({7'b0, pk[2]});
        exp_cmd_q.push_back({6'b101000, p}); rsp_q.push_back(8'h00);
        exp_cmd_q.push_back(8'h80); rsp_q.push_back({7'b0, ck[0]});
        exp_cmd_q.push_back(8'h81); rsp_q.push_back({7'b0, ck[1]});
        exp_cmd_q.push_back({7'b1010000, c}); rsp_q.push_back(8'h00);
        exp_cmd_q.push_back(8'hC0); rsp_q.push_back(8'h00);
        exp_cmd_q.push_back(8'hE0); rsp_q.push_back(board);
    endtask

    // Drives one start (held start_len cycles) and counts done/err pulses
    task automatic run_session(input logic [1:0] p, input logic c, input logic [2:0] pk,
                               input logic [1:0] ck, input logic [7:0] board, input bit shuf,
                               input int start_len, output int dones, output int errs);
        int fin;
        push_session(p, c, pk, ck, board, shuf);
        p_idx = p;
        c_idx = c;
        dones = 0;
        errs  = 0;
        fin   = 0;
        start = 1'b1;
        for (int i = 0; i < 3000 && fin < 3; i++) begin
            @(negedge clk);
            if (i + 1 >= start_len) start = 1'b0;
            if (done === 1'b1) dones++;
            if (err === 1'b1) errs++;
            if (dones > 0) fin++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        p_idx = 2'd0;
        c_idx = 1'b0;
        repeat (3) @(negedge clk);
        clear_core();
        n_tests++;
        if (all_outs !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: outputs=%h, required 0", all_outs);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut.stk_cnt !== 5'd17) begin
            n_fail++;
            $display("FAIL reset_stk: stk_cnt=%0d, required 17", dut.stk_cnt);
        end
        n_tests++;
        if (all_outs !== 28'd0) begin
            n_fail++;
            $display("FAIL idle_outputs: outputs=%h, required 0", all_outs);
        end
    endtask

    task automatic test_basic;
        int d, e;
        ready_delay = 0;
        rsp_delay   = 1;
        push_session(2'd1, 1'b0, 3'b101, 2'b10, 8'h11, 1'b0);
        p_idx = 2'd1;
        c_idx = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        d = 0;
        e = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done === 1'b1) d++;
            if (err === 1'b1) e++;
        end
        n_tests++;
        if (d !== 1 || e !== 0) begin
            n_fail++;
            $display("FAIL basic_done: done pulses=%0d err pulses=%0d, required 1 and 0", d, e);
        end
        n_tests++;
        if (exp_cmd_q.size() !== 0) begin
            n_fail++;
            $display("FAIL basic_cmds_left: pending=%0d, required 0", exp_cmd_q.size());
        end
        n_tests++;
        if ({peek3, peek2, played} !== {3'b101, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_hand: peek3=%b peek2=%b played=%b, required 101 10 1",
                     peek3, peek2, played);
        end
        n_tests++;
        if ({board_one, board_zero, win_one, win_zero, busy} !== {4'd1, 4'd1, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_board: one=%0d zero=%0d win=%b%b busy=%b, required 1 1 00 0",
                     board_one, board_zero, win_one, win_zero, busy);
        end
    endtask

    task automatic test_stall;
        int d, e, x0;
        ready_delay  = 5;
        rsp_delay    = 0;
        check_stable = 1'b1;
        x0 = xfer_cnt;
        run_session(2'd2, 1'b1, 3'b110, 2'b01, 8'h22, 1'b0, 4, d, e);
        check_stable = 1'b0;
        ready_delay  = 0;
        n_tests++;
        if (d !== 1 || e !== 0) begin
            n_fail++;
            $display("FAIL stall_done: done=%0d err=%0d, required 1 and 0", d, e);
        end
        n_tests++;
        if (xfer_cnt - x0 !== 9) begin
            n_fail++;
            $display("FAIL stall_xfers: transfers=%0d, required 9", xfer_cnt - x0);
        end
        n_tests++;
        if ({peek3, peek2, played} !== {3'b110, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_hand: peek3=%b peek2=%b played=%b, required 110 01 1",
                     peek3, peek2, played);
        end
    endtask

    task automatic test_bad_idx;
        int x0;
        logic seen_valid;
        x0 = xfer_cnt;
        p_idx = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_idx_err: err=%b busy=%b, required 1 0", err, busy);
        end
        seen_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_idx_pulse: err=%b, required 0", err);
        end
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen_valid !== 1'b0 || xfer_cnt !== x0) begin
            n_fail++;
            $display("FAIL bad_idx_cmd: cmd_valid seen=%b transfers=%0d, required 0 0",
                     seen_valid, xfer_cnt - x0);
        end
    endtask

    task automatic test_shuffle;
        int d, e;
        // stk_cnt 11 -> 8 -> 5 -> 2, last board has two zeros and three ones
        run_session(2'd0, 1'b0, 3'b001, 2'b01, 8'h11, 1'b0, 1, d, e);
        run_session(2'd2, 1'b1, 3'b010, 2'b10, 8'h21, 1'b0, 1, d, e);
        run_session(2'd1, 1'b0, 3'b111, 2'b11, 8'h32, 1'b0, 1, d, e);
        n_tests++;
        if (dut.stk_cnt !== 5'd2) begin
            n_fail++;
            $display("FAIL shuffle_pre_stk: stk_cnt=%0d, required 2", dut.stk_cnt);
        end
        stk_at_xfer.delete();
        run_session(2'd0, 1'b1, 3'b000, 2'b00, 8'h32, 1'b1, 1, d, e);
        n_tests++;
        if (d !== 1 || exp_cmd_q.size() !== 0) begin
            n_fail++;
            $display("FAIL shuffle_done: done=%0d pending=%0d, required 1 0", d, exp_cmd_q.size());
        end
        n_tests++;
        if (stk_at_xfer.size() < 2 || stk_at_xfer[1] !== 5'd12) begin
            n_fail++;
            $display("FAIL shuffle_stk_pk0: stk_cnt at PK0=%0d, required 12",
                     (stk_at_xfer.size() < 2) ? 0 : int'(stk_at_xfer[1]));
        end
        n_tests++;
        if (dut.stk_cnt !== 5'd9 || played !== 1'b0) begin
            n_fail++;
            $display("FAIL shuffle_post: stk_cnt=%0d played=%b, required 9 0", dut.stk_cnt, played);
        end
    endtask

    task automatic test_win;
        int d, e, x0;
        run_session(2'd1, 1'b1, 3'b011, 2'b11, 8'h60, 1'b0, 1, d, e);
        n_tests++;
        if ({board_one, board_zero, win_one, win_zero} !== {4'd6, 4'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL win_flags: one=%0d zero=%0d win_one=%b win_zero=%b, required 6 0 1 0",
                     board_one, board_zero, win_one, win_zero);
        end
        x0 = xfer_cnt;
        p_idx = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL win_restart_err: err=%b busy=%b, required 1 0", err, busy);
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (xfer_cnt !== x0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL win_restart_cmd: transfers=%0d cmd_valid=%b, required 0 0",
                     xfer_cnt - x0, cmd_valid);
        end
    endtask

    task automatic test_async_reset;
        int x0;
        bit reached;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_core();
        rst_n = 1'b1;
        @(negedge clk);
        rsp_delay = 3;
        x0 = xfer_cnt;
        push_session(2'd2, 1'b1, 3'b111, 2'b11, 8'h00, 1'b0);
        p_idx = 2'd2;
        c_idx = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (xfer_cnt - x0 >= 4) reached = 1'b1;
        end
        n_tests++;
        if (!reached || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reach_disp: reached=%b busy=%b, required 1 1", reached, busy);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: outputs=%h, required 0", all_outs);
        end
        repeat (10) @(negedge clk);
        clear_core();
        rsp_delay = 0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== 28'd0 || dut.stk_cnt !== 5'd17) begin
            n_fail++;
            $display("FAIL async_after: outputs=%h stk_cnt=%0d, required 0 17", all_outs, dut.stk_cnt);
        end
    endtask

`ifdef SNPU_SESSION_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        bit seen;
        clear_core();
        mute_idx = xfer_cnt + 1;
        exp_cmd_q.push_back(8'h80); rsp_q.push_back(8'h01);
        exp_cmd_q.push_back(8'h81);
        p_idx = 2'd0;
        c_idx = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin seen = 1'b1; cyc = i; end
        end
        n_tests++;
        if (!seen || cyc < 255 || cyc > 280) begin
            n_fail++;
            $display("FAIL timeout_err: seen=%b after %0d cycles, required 1 within 255..280", seen, cyc);
        end
        n_tests++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: busy=%b cmd_valid=%b, required 0 0", busy, cmd_valid);
        end
        clear_core();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        p_idx = 2'd0;
        c_idx = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_bad_idx();
        test_shuffle();
        test_win();
        test_async_reset();
`ifdef SNPU_SESSION_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
